// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the five-stage MIPS pipeline (F/D/E/M/W). The
// instruction in D is classified into sources, destination, Tuse and Tnew.
// That classification then travels through E/M/W shadow registers. From the
// shadows the block derives the D-stage stall, every forwarding select, and
// the HI/LO multiply/divide busy tracking.
//
// Ports
//   clk       in   core clock, rising edge
//   reset     in   asynchronous active-low reset; 0 clears all state at once
//   instr_d   in   [31:0] instruction currently in D
//   stall     out  freeze PC and F/D, insert bubble into D/E (combinational)
//   fwd_rs_d  out  [1:0] D rs select: 00 RF, 11 E (PC+8), 01 M, 10 W
//   fwd_rt_d  out  [1:0] D rt select, same encoding
//   fwd_rs_e  out  [1:0] E ALU rs select: 00 pipeline, 01 M, 10 W
//   fwd_rt_e  out  [1:0] E ALU rt select, same encoding
//   fwd_rt_m  out  M store-data select: 0 pipeline, 1 W
//   md_start  out  E holds mult/div (one pulse per instruction)
//   md_busy   out  HI/LO busy counter nonzero
//
// Handshake: there is no valid/ready pair here. stall is a combinational
// request back to F/D. While it is high, D holds and E receives a bubble.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_d,
   output logic        stall,
   output logic [1:0]  fwd_rs_d,
   output logic [1:0]  fwd_rt_d,
   output logic [1:0]  fwd_rs_e,
   output logic [1:0]  fwd_rt_e,
   output logic        fwd_rt_m,
   output logic        md_start,
   output logic        md_busy
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   // R-type function codes (op == 0)
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MTLO = 6'b010011;
   // Primary opcodes
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;

   // Per-stage classification. Unused sources are stored as register 0,
   // so they can never match a destination. is_div picks the reload value.
   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic       is_md;
      logic       is_div;
   } shadow_t;

   shadow_t sh_e, sh_m, sh_w;
   shadow_t dec_d;

   logic [CNT_W-1:0] md_cnt;

   // ------------------------------------------------------------------
   // D-stage decode
   // ------------------------------------------------------------------
   logic [5:0] op, funct;
   logic [4:0] f_rs, f_rt, f_rd;
   logic       use_rs, use_rt;
   logic [1:0] tuse_rs, tuse_rt;
   logic       md_op;        // any instruction that touches HI/LO

   assign op    = instr_d[31:26];
   assign f_rs  = instr_d[25:21];
   assign f_rt  = instr_d[20:16];
   assign f_rd  = instr_d[15:11];
   assign funct = instr_d[5:0];

   always_comb begin
      dec_d   = '0;
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      tuse_rs = 2'd0;
      tuse_rt = 2'd0;
      md_op   = 1'b0;
      if (op == 6'b000000) begin
         case (funct)
            F_ADDU, F_SUBU: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd1;
               use_rt      = 1'b1;
               tuse_rt     = 2'd1;
               dec_d.dst   = f_rd;
               dec_d.tnew  = 2'd1;
            end
            F_JR: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd0;
            end
            F_MULT, F_DIV: begin
               dec_d.valid  = 1'b1;
               use_rs       = 1'b1;
               tuse_rs      = 2'd1;
               use_rt       = 1'b1;
               tuse_rt      = 2'd1;
               md_op        = 1'b1;
               dec_d.is_md  = 1'b1;
               dec_d.is_div = (funct == F_DIV);
            end
            F_MFHI, F_MFLO: begin
               dec_d.valid = 1'b1;
               md_op       = 1'b1;
               dec_d.dst   = f_rd;
               dec_d.tnew  = 2'd1;
            end
            F_MTHI, F_MTLO: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd1;
               md_op       = 1'b1;
            end
            default: ;
         endcase
      end else begin
         case (op)
            OP_ORI: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd1;
               dec_d.dst   = f_rt;
               dec_d.tnew  = 2'd1;
            end
            OP_LUI: begin
               dec_d.valid = 1'b1;
               dec_d.dst   = f_rt;
               dec_d.tnew  = 2'd1;
            end
            OP_LW: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd1;
               dec_d.dst   = f_rt;
               dec_d.tnew  = 2'd2;
            end
            OP_SW: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd1;
               use_rt      = 1'b1;
               tuse_rt     = 2'd2;
            end
            OP_BEQ: begin
               dec_d.valid = 1'b1;
               use_rs      = 1'b1;
               tuse_rs     = 2'd0;
               use_rt      = 1'b1;
               tuse_rt     = 2'd0;
            end
            OP_J: begin
               dec_d.valid = 1'b1;
            end
            OP_JAL: begin
               dec_d.valid = 1'b1;
               dec_d.dst   = 5'd31;
               dec_d.tnew  = 2'd0;
            end
            default: ;
         endcase
      end
      dec_d.rs = use_rs ? f_rs : 5'd0;
      dec_d.rt = use_rt ? f_rt : 5'd0;
   end

   // ------------------------------------------------------------------
   // Stall: a producer still too young for the consumer's Tuse, or HI/LO
   // access while the multiply/divide unit is busy or just starting.
   // ------------------------------------------------------------------
   function automatic logic reg_haz(input logic [4:0] src, input logic [1:0] tuse,
                                    input shadow_t e, input shadow_t m);
      logic hit;
      hit = 1'b0;
      if (src != 5'd0) begin
         if (e.valid && e.dst == src && e.tnew > tuse) hit = 1'b1;
         if (m.valid && m.dst == src && m.tnew > tuse) hit = 1'b1;
      end
      return hit;
   endfunction

   logic haz_rs, haz_rt, haz_md;

   assign haz_rs = reg_haz(dec_d.rs, tuse_rs, sh_e, sh_m);
   assign haz_rt = reg_haz(dec_d.rt, tuse_rt, sh_e, sh_m);
   assign haz_md = md_op && (md_busy || md_start);
   assign stall  = haz_rs || haz_rt || haz_md;

   // ------------------------------------------------------------------
   // Forwarding. The nearest stage whose value is already produced wins.
   // E only qualifies for jal (tnew 0 on entry). W must always be
   // considered because the register file is not write-through.
   // ------------------------------------------------------------------
   function automatic logic stage_hit(input logic [4:0] src, input shadow_t s);
      return (src != 5'd0) && s.valid && (s.dst == src) && (s.tnew == 2'd0);
   endfunction

   function automatic logic [1:0] sel_d(input logic [4:0] src, input shadow_t e,
                                        input shadow_t m, input shadow_t w);
      if (stage_hit(src, e))      return 2'b11;
      else if (stage_hit(src, m)) return 2'b01;
      else if (stage_hit(src, w)) return 2'b10;
      else                        return 2'b00;
   endfunction

   function automatic logic [1:0] sel_e(input logic [4:0] src, input shadow_t m,
                                        input shadow_t w);
      if (stage_hit(src, m))      return 2'b01;
      else if (stage_hit(src, w)) return 2'b10;
      else                        return 2'b00;
   endfunction

   assign fwd_rs_d = sel_d(dec_d.rs, sh_e, sh_m, sh_w);
   assign fwd_rt_d = sel_d(dec_d.rt, sh_e, sh_m, sh_w);
   assign fwd_rs_e = sel_e(sh_e.rs, sh_m, sh_w);
   assign fwd_rt_e = sel_e(sh_e.rt, sh_m, sh_w);
   assign fwd_rt_m = stage_hit(sh_m.rt, sh_w);

   assign md_start = sh_e.is_md;
   assign md_busy  = (md_cnt != '0);

   // ------------------------------------------------------------------
   // Shadow pipeline and HI/LO busy counter
   // ------------------------------------------------------------------
   function automatic shadow_t age(input shadow_t s);
      shadow_t r;
      r      = s;
      r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_e   <= '0;
         sh_m   <= '0;
         sh_w   <= '0;
         md_cnt <= '0;
      end else begin
         sh_e <= stall ? '0 : dec_d;
         sh_m <= age(sh_e);
         sh_w <= age(sh_m);
         if (sh_e.is_md)
            md_cnt <= sh_e.is_div ? DIV_LD : MULT_LD;
         else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
      end
   end

   // Fields that are carried for completeness but not consumed downstream.
   logic unused_bits;
   assign unused_bits = ^{instr_d[10:6], sh_m.rs, sh_m.is_md, sh_m.is_div,
                          sh_w.rs, sh_w.rt, sh_w.is_md, sh_w.is_div};

endmodule
